// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver (5-8 data bits, none/even/odd parity,
// 1 or 2 stop bits). The pin is synchronised, each bit is decided by a 3-sample
// majority vote around mid-bit, and completed frames land in a valid/ready
// holding register that reports overrun when the consumer falls behind.
module uart_rx_cfg #(
  parameter int OVS         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       s_tick,
  input  logic [1:0] cfg_dbit,
  input  logic [1:0] cfg_par,
  input  logic       cfg_stop2,
  input  logic       rx_ready,
  output logic       rx_valid,
  output logic [7:0] dout,
  output logic       par_err,
  output logic       frame_err,
  output logic       brk,
  output logic       overrun,
  output logic       rx_done_tick,
  output logic       busy
);

  localparam int SW = $clog2(OVS);
  localparam logic [SW-1:0] S_LO  = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_MID = SW'(OVS / 2);
  localparam logic [SW-1:0] S_HI  = SW'(OVS / 2 + 1);
  localparam logic [SW-1:0] S_END = SW'(OVS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic [SW-1:0]          s_q, s_d;
  logic [2:0]             n_q, n_d;
  logic [7:0]             shreg_q, shreg_d;
  logic [1:0]             samp_q, samp_d;
  logic [1:0]             dbit_q, dbit_d;
  logic [1:0]             par_q, par_d;
  logic                   stop2_q, stop2_d;
  logic                   stop_n_q, stop_n_d;   // 1 while in the second stop bit
  logic                   perr_c_q, perr_c_d;   // per-frame error candidates
  logic                   ferr_c_q, ferr_c_d;
  logic                   brk_c_q, brk_c_d;
  logic                   zero_q, zero_d;       // every data/parity bit so far was 0
  logic                   wait_hi_q, wait_hi_d; // line must go high before a new start
  logic [7:0]             dout_q, dout_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   brk_q, brk_d;
  logic                   valid_q, valid_d;
  logic                   ovr_q, ovr_d;
  logic                   done_q, done_d;

  logic                   maj;
  logic                   par_en;
  logic [2:0]             n_last;

  assign rxs    = sync_q[SYNC_STAGES-1];
  // Two stored samples plus the live third sample, evaluated at s = OVS/2+1
  assign maj    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);
  assign par_en = (par_q == 2'b01) || (par_q == 2'b10);
  assign n_last = {1'b0, dbit_q} + 3'd4;

  // Pin synchroniser; flops idle high so reset does not look like a start bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      s_q       <= '0;
      n_q       <= '0;
      shreg_q   <= '0;
      samp_q    <= '0;
      dbit_q    <= '0;
      par_q     <= '0;
      stop2_q   <= 1'b0;
      stop_n_q  <= 1'b0;
      perr_c_q  <= 1'b0;
      ferr_c_q  <= 1'b0;
      brk_c_q   <= 1'b0;
      zero_q    <= 1'b0;
      wait_hi_q <= 1'b0;
      dout_q    <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      brk_q     <= 1'b0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      shreg_q   <= shreg_d;
      samp_q    <= samp_d;
      dbit_q    <= dbit_d;
      par_q     <= par_d;
      stop2_q   <= stop2_d;
      stop_n_q  <= stop_n_d;
      perr_c_q  <= perr_c_d;
      ferr_c_q  <= ferr_c_d;
      brk_c_q   <= brk_c_d;
      zero_q    <= zero_d;
      wait_hi_q <= wait_hi_d;
      dout_q    <= dout_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      brk_q     <= brk_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
      done_q    <= done_d;
    end
  end

  // Next-state: bit timing, frame sequencing and holding-register update
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    n_d       = n_q;
    shreg_d   = shreg_q;
    samp_d    = samp_q;
    dbit_d    = dbit_q;
    par_d     = par_q;
    stop2_d   = stop2_q;
    stop_n_d  = stop_n_q;
    perr_c_d  = perr_c_q;
    ferr_c_d  = ferr_c_q;
    brk_c_d   = brk_c_q;
    zero_d    = zero_q;
    wait_hi_d = wait_hi_q & ~rxs;
    dout_d    = dout_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    brk_d     = brk_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    done_d    = 1'b0;

    if (s_tick && state_q != IDLE) begin
      if (s_q == S_LO)  samp_d[0] = rxs;
      if (s_q == S_MID) samp_d[1] = rxs;
      s_d = (s_q == S_END) ? '0 : s_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (!rxs && !wait_hi_q) begin
          state_d  = START;
          s_d      = '0;
          n_d      = '0;
          shreg_d  = '0;
          dbit_d   = cfg_dbit;
          par_d    = cfg_par;
          stop2_d  = cfg_stop2;
          stop_n_d = 1'b0;
          perr_c_d = 1'b0;
          ferr_c_d = 1'b0;
          brk_c_d  = 1'b0;
          zero_d   = 1'b1;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_HI && maj) state_d = IDLE;   // glitch, not a real start bit
          else if (s_q == S_END) begin
            state_d = DATA;
            n_d     = '0;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_HI) begin
            shreg_d[n_q] = maj;
            if (maj) zero_d = 1'b0;
          end
          if (s_q == S_END) begin
            if (n_q == n_last) state_d = par_en ? PARITY : STOP;
            else               n_d = n_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s_q == S_HI) begin
            if (maj) zero_d = 1'b0;
            perr_c_d = ((^shreg_q) ^ maj) != (par_q == 2'b10);
          end
          if (s_q == S_END) state_d = STOP;
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == S_HI) begin
            if (!maj) ferr_c_d = 1'b1;
            if (!stop_n_q) brk_c_d = zero_q & ~maj;
            // Finish at mid-bit of the last stop so a back-to-back start edge is seen
            if (stop_n_q || !stop2_q) begin
              done_d  = 1'b1;
              state_d = IDLE;
              // A low stop bit means the line may still be held low (break);
              // do not re-arm until it has been seen high again.
              if (!maj) wait_hi_d = 1'b1;
            end
          end else if (s_q == S_END) begin
            stop_n_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (done_d) begin
      if (!valid_q || rx_ready) begin
        dout_d  = shreg_q;
        perr_d  = perr_c_q;
        ferr_d  = ferr_c_d;
        brk_d   = brk_c_d;
        valid_d = 1'b1;
        ovr_d   = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  // Outputs straight from registers
  always_comb begin
    rx_valid     = valid_q;
    dout         = dout_q;
    par_err      = perr_q;
    frame_err    = ferr_q;
    brk          = brk_q;
    overrun      = ovr_q;
    rx_done_tick = done_q;
    busy         = (state_q != IDLE);
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: drives serial frames bit by bit against a
// free-running s_tick (one pulse every TDIV clocks) and checks the holding
// register, flags and pulse counts against hand-computed values.
module tb_uart_rx_cfg;
  localparam int OVS     = 16;
  localparam int TDIV    = 4;
  localparam int BIT_CLK = OVS * TDIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       s_tick = 1'b0;
  logic [1:0] cfg_dbit = 2'b11;
  logic [1:0] cfg_par = 2'b00;
  logic       cfg_stop2 = 1'b0;
  logic       rx_ready = 1'b1;
  logic       rx_valid;
  logic [7:0] dout;
  logic       par_err, frame_err, brk, overrun, rx_done_tick, busy;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int valid_cyc = 0;
  logic [7:0] hist0 = 8'h00, hist1 = 8'h00;

  uart_rx_cfg #(.OVS(OVS), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .rx(rx), .s_tick(s_tick),
    .cfg_dbit(cfg_dbit), .cfg_par(cfg_par), .cfg_stop2(cfg_stop2),
    .rx_ready(rx_ready), .rx_valid(rx_valid), .dout(dout),
    .par_err(par_err), .frame_err(frame_err), .brk(brk), .overrun(overrun),
    .rx_done_tick(rx_done_tick), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (TDIV - 1) @(posedge clk);
      #1 s_tick = 1'b1;
      @(posedge clk);
      #1 s_tick = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rx_done_tick) begin
      done_cnt <= done_cnt + 1;
      hist1    <= hist0;
      hist0    <= dout;
    end
    if (rx_valid) valid_cyc <= valid_cyc + 1;
  end

  function automatic logic [31:0] frame8n1(input logic [7:0] d);
    return {22'h3FFFFF, 1'b1, d, 1'b0};
  endfunction

  // Bits go out LSB first; a glitch bit is inverted for one tick period near mid-bit
  task automatic send_bits(input logic [31:0] bits, input int n, input logic [31:0] gmask);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < BIT_CLK; c++) begin
        rx = (gmask[i] && c >= 34 && c < 38) ? ~bits[i] : bits[i];
        @(posedge clk); #1;
      end
    end
    rx = 1'b1;
  endtask

  task automatic idle_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; rx = 1'b1;
    idle_clks(3);
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rx_valid); end checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", dout); end checks++;
    if ({par_err, frame_err, brk, overrun} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {par_err, frame_err, brk, overrun}); end checks++;
    if (rx_done_tick !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", rx_done_tick); end checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end checks++;
    reset = 1'b0;
    idle_clks(BIT_CLK);
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end checks++;
    $display("test_reset done");
  endtask

  task automatic test_8n1();
    int d0, v0;
    d0 = done_cnt; v0 = valid_cyc;
    cfg_dbit = 2'b11; cfg_par = 2'b00; cfg_stop2 = 1'b0; rx_ready = 1'b1;
    send_bits(frame8n1(8'hA5), 10, 32'h0);
    idle_clks(4);
    $display("8N1 frame: dout=%h done=%0d", dout, done_cnt - d0);
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL 8n1_done_count: got %0d want 1", done_cnt - d0); end checks++;
    if (dout !== 8'hA5) begin errors++; $display("FAIL 8n1_dout: got %h want a5", dout); end checks++;
    if ({par_err, frame_err, brk, overrun} !== 4'b0000) begin errors++; $display("FAIL 8n1_flags: got %b want 0000", {par_err, frame_err, brk, overrun}); end checks++;
    if (valid_cyc - v0 !== 1) begin errors++; $display("FAIL 8n1_valid_cycles: got %0d want 1", valid_cyc - v0); end checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL 8n1_busy: got %b want 0", busy); end checks++;
  endtask

  task automatic test_parity();
    int d0;
    // 7E2, 0x35 has four ones so the correct even parity bit is 0; send 1
    d0 = done_cnt;
    cfg_dbit = 2'b10; cfg_par = 2'b01; cfg_stop2 = 1'b1; rx_ready = 1'b1;
    send_bits({21'h1FFFFF, 2'b11, 1'b1, 7'h35, 1'b0}, 11, 32'h0);
    idle_clks(4);
    $display("7E2 frame: dout=%h par_err=%b frame_err=%b", dout, par_err, frame_err);
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL 7e2_done_count: got %0d want 1", done_cnt - d0); end checks++;
    if (dout !== 8'h35) begin errors++; $display("FAIL 7e2_dout: got %h want 35", dout); end checks++;
    if (par_err !== 1'b1) begin errors++; $display("FAIL 7e2_par_err: got %b want 1", par_err); end checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL 7e2_frame_err: got %b want 0", frame_err); end checks++;
    // 6O1, 0x2A has three ones so odd parity bit is 0 (correct); stop bit sent low
    d0 = done_cnt;
    cfg_dbit = 2'b01; cfg_par = 2'b10; cfg_stop2 = 1'b0;
    send_bits({23'h7FFFFF, 1'b0, 1'b0, 6'h2A, 1'b0}, 9, 32'h0);
    idle_clks(BIT_CLK);
    $display("6O1 frame: dout=%h par_err=%b frame_err=%b brk=%b", dout, par_err, frame_err, brk);
    if (dout !== 8'h2A) begin errors++; $display("FAIL 6o1_dout: got %h want 2a", dout); end checks++;
    if ({par_err, frame_err, brk} !== 3'b010) begin errors++; $display("FAIL 6o1_flags: got %b want 010", {par_err, frame_err, brk}); end checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL 6o1_done_count: got %0d want 1", done_cnt - d0); end checks++;
  endtask

  task automatic test_false_start();
    int d0;
    d0 = done_cnt;
    cfg_dbit = 2'b11; cfg_par = 2'b00; cfg_stop2 = 1'b0;
    rx = 1'b0;
    idle_clks(10);
    if (busy !== 1'b1) begin errors++; $display("FAIL false_start_busy_hi: got %b want 1", busy); end checks++;
    idle_clks(4 * TDIV - 10);
    rx = 1'b1;
    idle_clks(BIT_CLK);
    $display("false start: busy=%b done=%0d", busy, done_cnt - d0);
    if (busy !== 1'b0) begin errors++; $display("FAIL false_start_busy_lo: got %b want 0", busy); end checks++;
    if (done_cnt - d0 !== 0) begin errors++; $display("FAIL false_start_done: got %0d want 0", done_cnt - d0); end checks++;
  endtask

  task automatic test_break();
    int d0;
    d0 = done_cnt;
    cfg_dbit = 2'b11; cfg_par = 2'b00; cfg_stop2 = 1'b0; rx_ready = 1'b1;
    rx = 1'b0;
    idle_clks(12 * BIT_CLK);
    $display("break: dout=%h frame_err=%b brk=%b", dout, frame_err, brk);
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL break_done_count: got %0d want 1", done_cnt - d0); end checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL break_dout: got %h want 00", dout); end checks++;
    if ({par_err, frame_err, brk} !== 3'b011) begin errors++; $display("FAIL break_flags: got %b want 011", {par_err, frame_err, brk}); end checks++;
    rx = 1'b1;
    idle_clks(10 * BIT_CLK);
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL break_no_rearm: got %0d want 1", done_cnt - d0); end checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL break_busy: got %b want 0", busy); end checks++;
  endtask

  task automatic test_overrun();
    int d0;
    d0 = done_cnt;
    cfg_dbit = 2'b11; cfg_par = 2'b00; cfg_stop2 = 1'b0; rx_ready = 1'b0;
    send_bits(frame8n1(8'h11), 10, 32'h0);
    send_bits(frame8n1(8'h22), 10, 32'h0);
    idle_clks(4);
    $display("overrun: dout=%h overrun=%b valid=%b", dout, overrun, rx_valid);
    if (done_cnt - d0 !== 2) begin errors++; $display("FAIL ovr_done_count: got %0d want 2", done_cnt - d0); end checks++;
    if (dout !== 8'h11) begin errors++; $display("FAIL ovr_dout_held: got %h want 11", dout); end checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag_set: got %b want 1", overrun); end checks++;
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b want 1", rx_valid); end checks++;
    rx_ready = 1'b1;
    send_bits(frame8n1(8'h33), 10, 32'h0);
    idle_clks(4);
    $display("third frame: dout=%h overrun=%b", dout, overrun);
    if (dout !== 8'h33) begin errors++; $display("FAIL ovr_dout_third: got %h want 33", dout); end checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_flag_clear: got %b want 0", overrun); end checks++;
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_cnt;
    rx_ready = 1'b1;
    send_bits({12'hFFF, 1'b1, 8'hC3, 1'b0, 1'b1, 8'h3C, 1'b0}, 20, 32'h0);
    idle_clks(4);
    $display("back-to-back: first=%h second=%h", hist1, hist0);
    if (done_cnt - d0 !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt - d0); end checks++;
    if (hist1 !== 8'h3C) begin errors++; $display("FAIL b2b_first: got %h want 3c", hist1); end checks++;
    if (hist0 !== 8'hC3) begin errors++; $display("FAIL b2b_second: got %h want c3", hist0); end checks++;
  endtask

  task automatic test_glitch();
    int d0;
    d0 = done_cnt;
    rx_ready = 1'b0;
    send_bits(frame8n1(8'h5A), 10, 32'h1FE);
    idle_clks(4);
    $display("glitched frame: dout=%h", dout);
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL glitch_done_count: got %0d want 1", done_cnt - d0); end checks++;
    if (dout !== 8'h5A) begin errors++; $display("FAIL glitch_dout: got %h want 5a", dout); end checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL glitch_frame_err: got %b want 0", frame_err); end checks++;
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL glitch_valid: got %b want 1", rx_valid); end checks++;
  endtask

  task automatic test_reset_mid_frame();
    int d0;
    d0 = done_cnt;
    send_bits(frame8n1(8'h00), 4, 32'h0);
    if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b want 1", busy); end checks++;
    reset = 1'b1;
    #1;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", rx_valid); end checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL midrst_dout: got %h want 00", dout); end checks++;
    rx = 1'b1;
    idle_clks(3);
    reset = 1'b0;
    idle_clks(2 * BIT_CLK);
    $display("reset mid-frame: busy=%b done=%0d", busy, done_cnt - d0);
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle: got %b want 0", busy); end checks++;
    if (done_cnt - d0 !== 0) begin errors++; $display("FAIL midrst_done: got %0d want 0", done_cnt - d0); end checks++;
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_8n1();
    test_parity();
    test_false_start();
    test_break();
    test_overrun();
    test_back_to_back();
    test_glitch();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
